// File: rtl/sudoku_puzzle_loader_if.sv
// Puzzle word stream: valid/ready handshake carrying 8 BCD digits per word.
interface sudoku_puzzle_loader_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/sudoku_puzzle_loader.sv
// Unpacks a BCD puzzle frame into one-hot cells, then starts the solver and
// blocks further input until the solver reports done.
module sudoku_puzzle_loader #(
    parameter int WIDTH           = 9,
    parameter int DIGITS_PER_WORD = 8,
    parameter int NUM_WORDS       = 11
) (
    input  logic                           clk,
    input  logic                           reset,
    sudoku_puzzle_loader_if.slave          in_if,
    output logic [WIDTH*WIDTH*WIDTH-1:0]   initial_vals,
    output logic                           solver_start,
    input  logic                           solver_done,
    output logic                           busy,
    output logic                           err_digit,
    output logic                           err_frame
);
    localparam int NCELLS = WIDTH * WIDTH;
    localparam int CW     = $clog2(NUM_WORDS + 1);
    localparam int DPW    = DIGITS_PER_WORD;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_t;

    state_t                       r_state, w_next;
    logic [CW-1:0]                r_cnt;
    logic [CW-1:0]                w_word;
    logic                         w_fire;
    logic                         w_last_word;
    logic                         w_frame_err;
    logic                         w_bad_nib;
    logic [DPW-1:0]               w_nib_bad;
    logic [DPW-1:0][WIDTH-1:0]    w_dec;
    logic [NCELLS-1:0][WIDTH-1:0] r_cells;
    logic                         r_err_digit;
    logic                         r_err_frame;

    assign w_fire      = in_if.in_valid && in_if.in_ready;
    // The IDLE word is always word 0; the counter only tracks words inside LOAD.
    assign w_word      = (r_state == S_LOAD) ? r_cnt : '0;
    assign w_last_word = (w_word == CW'(NUM_WORDS - 1));
    assign w_frame_err = w_fire && (in_if.in_last != w_last_word);
    assign w_bad_nib   = |w_nib_bad;

    for (genvar k = 0; k < DPW; k++) begin : g_nib
        localparam int LIM = (NCELLS - k + DPW - 1) / DPW;
        logic [3:0] w_nib;
        assign w_nib        = in_if.in_data[4*k +: 4];
        assign w_dec[k]     = (w_nib >= 4'd1 && w_nib <= 4'(WIDTH))
                              ? (WIDTH'(1) << (w_nib - 4'd1)) : '0;
        // Nibbles past the last cell of the grid are padding and never flag errors.
        assign w_nib_bad[k] = (w_nib > 4'(WIDTH)) && (w_word < CW'(LIM));
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_fire) w_next = in_if.in_last ? S_IDLE : S_LOAD;
            S_LOAD: begin
                if (w_fire) begin
                    if (w_last_word && in_if.in_last)      w_next = S_START;
                    else if (w_last_word || in_if.in_last) w_next = S_IDLE;
                end
            end
            S_START: w_next = S_WAIT;
            S_WAIT:  if (solver_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_if.in_ready = 1'b0;
        solver_start   = 1'b0;
        busy           = 1'b0;
        case (r_state)
            S_IDLE:  in_if.in_ready = 1'b1;
            S_LOAD: begin
                in_if.in_ready = 1'b1;
                busy           = 1'b1;
            end
            S_START: begin
                solver_start = 1'b1;
                busy         = 1'b1;
            end
            S_WAIT:  busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_err_digit <= 1'b0;
            r_err_frame <= 1'b0;
        end else begin
            r_err_frame <= w_frame_err;
            if (w_fire) begin
                r_cnt       <= (w_next == S_LOAD) ? (w_word + CW'(1)) : '0;
                r_err_digit <= ((r_state == S_IDLE) ? 1'b0 : r_err_digit) | w_bad_nib;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cells <= '0;
        end else begin
            for (int c = 0; c < NCELLS; c++) begin
                if (w_fire && w_word == CW'(c / DPW))
                    r_cells[c] <= w_dec[c % DPW];
            end
        end
    end

    assign initial_vals = r_cells;
    assign err_digit    = r_err_digit;
    assign err_frame    = r_err_frame;
endmodule

// File: tb/tb_sudoku_puzzle_loader.sv
// Directed + randomized bench for the puzzle loader with a cell-level reference model.
module tb_sudoku_puzzle_loader;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         solver_done = 1'b0;
    logic [728:0] initial_vals;
    logic         solver_start, busy, err_digit, err_frame;

    int checks = 0, errors = 0;
    int fires = 0, starts = 0, frame_errs = 0;
    int exp_starts = 0;

    logic [31:0] words[12];
    bit   [3:0]  dig[81];

    sudoku_puzzle_loader_if ifc();

    sudoku_puzzle_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_if        (ifc.slave),
        .initial_vals (initial_vals),
        .solver_start (solver_start),
        .solver_done  (solver_done),
        .busy         (busy),
        .err_digit    (err_digit),
        .err_frame    (err_frame)
    );

    always #5 clk = ~clk;

    // Inputs are stable at the falling edge, so a fire seen here happens on the next rising edge.
    always @(negedge clk) begin
        if (!reset && ifc.in_valid && ifc.in_ready) fires <= fires + 1;
        if (solver_start) starts <= starts + 1;
        if (err_frame) frame_errs <= frame_errs + 1;
    end

    task automatic chk(input string tag, input logic [728:0] obs, input logic [728:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] nib_of(input int c);
        logic [31:0] w;
        w = words[c / 8];
        return 4'(w >> (4 * (c % 8)));
    endfunction

    // Reference: every grid cell decoded straight from the frame words.
    function automatic logic [728:0] model_vals();
        logic [728:0] v;
        logic [3:0]   n;
        v = '0;
        for (int c = 0; c < 81; c++) begin
            n = nib_of(c);
            if (n >= 1 && n <= 9) v[9*c +: 9] = 9'(1 << (n - 1));
        end
        return v;
    endfunction

    function automatic bit model_derr(input int ncells);
        bit b;
        b = 0;
        for (int c = 0; c < ncells; c++) if (nib_of(c) > 9) b = 1;
        return b;
    endfunction

    function automatic void build(input logic [27:0] fill);
        for (int w = 0; w < 12; w++) words[w] = '0;
        for (int c = 0; c < 81; c++) words[c / 8][4*(c % 8) +: 4] = dig[c];
        words[10][31:4] = fill;
        words[11] = 32'h1234_5678;
    endfunction

    function automatic void rand_digits(input int bad_pct);
        for (int c = 0; c < 81; c++)
            dig[c] = ($urandom_range(0, 99) < bad_pct) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
    endfunction

    task automatic send_word(input logic [31:0] d, input bit last, input int gap);
        int w;
        w = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        ifc.in_last  = last;
        while (!ifc.in_ready && w < 100) begin
            tick();
            w++;
        end
        if (w >= 100) chk("ready_timeout", ifc.in_ready, 1);
        tick();
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        repeat (gap) tick();
    endtask

    // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps
    task automatic run_frame(input int mode);
        int f0, s0, gap;
        bit ed;
        logic [728:0] ev;
        f0 = fires;
        s0 = starts;
        ed = model_derr(81);
        ev = model_vals();
        for (int w = 0; w < 11; w++) begin
            gap = (w == 10 || mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
            send_word(words[w], w == 10, gap);
            if (w == 0 && gap == 0) chk("derr_first_fire", err_digit, model_derr(8));
        end
        chk("start_pulse", solver_start, 1);
        chk("ready_in_start", ifc.in_ready, 0);
        chk("err_frame_clean", err_frame, 0);
        chk("err_digit", err_digit, ed);
        chk("vals", initial_vals, ev);
        exp_starts++;
        tick();
        chk("start_one_cycle", solver_start, 0);
        chk("busy_wait", busy, 1);
        chk("vals_stable", initial_vals, ev);
        chk("fire_count", fires - f0, 11);
        chk("start_count", starts - s0, 1);
    endtask

    task automatic release_solver();
        solver_done = 1'b1;
        tick();
        solver_done = 1'b0;
        chk("ready_after_done", ifc.in_ready, 1);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vals"}, initial_vals, '0);
        chk({tag, "_ready"}, ifc.in_ready, 1);
        chk({tag, "_start"}, solver_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_derr"}, err_digit, 0);
        chk({tag, "_ferr"}, err_frame, 0);
    endtask

    initial begin
        int f, s, fe;
        bit seen_ready;
        ifc.in_valid = 1'b0;
        ifc.in_data  = '0;
        ifc.in_last  = 1'b0;
        repeat (3) tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        // Continuous frame, cell k holds digit k%10
        for (int c = 0; c < 81; c++) dig[c] = 4'(c % 10);
        build('0);
        run_frame(0);
        chk("cell0", initial_vals[8:0], 9'b0);
        chk("cell1", initial_vals[17:9], 9'b000000001);
        chk("cell9", initial_vals[89:81], 9'b100000000);
        release_solver();

        // Same frame with valid toggling; solver held busy while a word waits
        run_frame(1);
        chk("cell9_toggle", initial_vals[89:81], 9'b100000000);
        f = fires;
        ifc.in_valid = 1'b1;
        ifc.in_data  = 32'h0000_0001;
        ifc.in_last  = 1'b1;
        seen_ready = 0;
        repeat (20) begin
            tick();
            if (ifc.in_ready) seen_ready = 1;
        end
        chk("ready_low_in_wait", seen_ready, 0);
        chk("no_fire_in_wait", fires - f, 0);
        solver_done = 1'b1;
        tick();
        solver_done = 1'b0;
        chk("ready_next_cycle", ifc.in_ready, 1);
        tick();
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        chk("held_word_fired", fires - f, 1);
        chk("idle_last_ferr", err_frame, 1);
        chk("idle_last_busy", busy, 0);
        tick();
        chk("ferr_pulse_end", err_frame, 0);

        // Bad digit in cell 26, padding nibbles of word 10 all 0xF
        rand_digits(0);
        dig[26] = 4'hC;
        build(28'hFFF_FFFF);
        run_frame(0);
        chk("cell26_zero", initial_vals[242:234], 9'b0);
        chk("err_digit_bad", err_digit, 1);
        release_solver();
        dig[26] = 4'h5;
        build(28'hFFF_FFFF);
        run_frame(0);
        chk("padding_ignored", err_digit, 0);
        release_solver();

        // in_last on word 5
        rand_digits(0);
        build('0);
        s = starts;
        for (int w = 0; w < 6; w++) send_word(words[w], w == 5, 0);
        chk("early_last_ferr", err_frame, 1);
        chk("early_last_ready", ifc.in_ready, 1);
        chk("early_last_busy", busy, 0);
        tick();
        chk("early_last_ferr_end", err_frame, 0);
        chk("early_last_nostart", starts - s, 0);

        // Twelve-word frame with no in_last
        fe = frame_errs;
        for (int w = 0; w < 11; w++) send_word(words[w], 1'b0, 0);
        chk("no_last_ferr", err_frame, 1);
        chk("no_last_busy", busy, 0);
        chk("no_last_start", solver_start, 0);
        send_word(words[11], 1'b0, 0);
        chk("word11_new_frame", busy, 1);
        chk("no_last_ferr_count", frame_errs - fe, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Reset mid-frame after word 6
        rand_digits(0);
        dig[20] = 4'hA;
        build('0);
        for (int w = 0; w < 7; w++) send_word(words[w], 1'b0, 0);
        chk("mid_frame_derr", err_digit, 1);
        chk("mid_frame_busy", busy, 1);
        s = starts;
        reset = 1'b1;
        tick();
        chk_reset_vals("midreset");
        reset = 1'b0;
        tick();
        chk("midreset_nostart", starts - s, 0);
        rand_digits(0);
        build('0);
        run_frame(2);
        release_solver();

        // Random frames, occasional bad digits, random gaps
        for (int i = 0; i < 6; i++) begin
            rand_digits(8);
            build(28'($urandom));
            run_frame(2);
            repeat ($urandom_range(0, 3)) tick();
            release_solver();
        end

        chk("total_starts", starts, exp_starts);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
